// File: rtl/kernel_bram_pingpong_ctrl.sv
// Ping-pong kernel BRAM controller: AXI-Stream writes fill one bank while the
// convolution datapath reads channel words from the other bank.
module kernel_bram_pingpong_ctrl #(
  parameter int unsigned DATA_W = 72,
  parameter int unsigned MAX_CH = 256,
  parameter int unsigned CH_W   = 9,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [CH_W-1:0]   cfg_channels,
  input  logic              load_req,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              bram_a_en,
  output logic              bram_a_we,
  output logic [ADDR_W:0]   bram_a_addr,
  output logic [DATA_W-1:0] bram_a_din,
  input  logic              rd_req,
  input  logic              rd_next,
  output logic              bram_b_en,
  output logic [ADDR_W:0]   bram_b_addr,
  output logic              rd_valid,
  output logic              last_channel,
  output logic [1:0]        bank_full,
  output logic              load_done,
  output logic              tlast_err,
  output logic              cfg_err
);

  typedef enum logic {W_IDLE, W_LOAD}   w_state_e;
  typedef enum logic {R_IDLE, R_ACTIVE} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] a_cnt_q, a_cnt_d;
  logic [ADDR_W-1:0] b_cnt_q, b_cnt_d;
  logic [CH_W-1:0]   wch_q, wch_d;
  logic [CH_W-1:0]   rch_q, rch_d;
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [1:0]        full_set, full_clr;
  logic              rd_valid_q, rd_valid_d;
  logic              load_done_q, load_done_d;
  logic              tlast_err_q, tlast_err_d;
  logic              en_q;
  logic              beat, w_final, r_last, r_accept;

  assign cfg_err  = (cfg_channels == '0) || (cfg_channels > CH_W'(MAX_CH));
  assign beat     = (w_state_q == W_LOAD) && s_axis_tvalid;
  assign w_final  = (CH_W'(a_cnt_q) == (wch_q - CH_W'(1)));
  assign r_last   = (r_state_q == R_ACTIVE) && (CH_W'(b_cnt_q) == (rch_q - CH_W'(1)));
  assign r_accept = (r_state_q == R_ACTIVE) && rd_valid_q && rd_next;

  // A fill and a drain always target different banks, so both may apply at once.
  assign bank_full_d = (bank_full_q | full_set) & ~full_clr;

  // Write side: one kernel per load_req into bank wb.
  always_comb begin
    w_state_d   = w_state_q;
    a_cnt_d     = a_cnt_q;
    wch_d       = wch_q;
    wb_d        = wb_q;
    full_set    = 2'b00;
    load_done_d = 1'b0;
    tlast_err_d = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (load_req && !bank_full_q[wb_q] && !cfg_err) begin
          w_state_d = W_LOAD;
          wch_d     = cfg_channels;
          a_cnt_d   = '0;
        end
      end
      W_LOAD: begin
        if (beat) begin
          if (w_final) begin
            full_set[wb_q] = 1'b1;
            wb_d           = ~wb_q;
            load_done_d    = 1'b1;
            tlast_err_d    = ~s_axis_tlast;
            a_cnt_d        = '0;
            w_state_d      = W_IDLE;
          end else if (s_axis_tlast) begin
            tlast_err_d = 1'b1;
            a_cnt_d     = '0;
            w_state_d   = W_IDLE;
          end else begin
            a_cnt_d = a_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read side: rd_valid is the 1-cycle BRAM latency after every address change.
  always_comb begin
    r_state_d  = r_state_q;
    b_cnt_d    = b_cnt_q;
    rch_d      = rch_q;
    rb_d       = rb_q;
    full_clr   = 2'b00;
    rd_valid_d = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rd_req && bank_full_q[rb_q]) begin
          r_state_d = R_ACTIVE;
          rch_d     = cfg_channels;
          b_cnt_d   = '0;
        end
      end
      R_ACTIVE: begin
        if (r_accept) begin
          if (r_last) begin
            full_clr[rb_q] = 1'b1;
            rb_d           = ~rb_q;
            b_cnt_d        = '0;
            r_state_d      = R_IDLE;
          end else begin
            b_cnt_d = b_cnt_q + ADDR_W'(1);
          end
        end else begin
          rd_valid_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      wch_q       <= '0;
      rch_q       <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      bank_full_q <= 2'b00;
      rd_valid_q  <= 1'b0;
      load_done_q <= 1'b0;
      tlast_err_q <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      wch_q       <= wch_d;
      rch_q       <= rch_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      bank_full_q <= bank_full_d;
      rd_valid_q  <= rd_valid_d;
      load_done_q <= load_done_d;
      tlast_err_q <= tlast_err_d;
      en_q        <= 1'b1;
    end
  end

  assign s_axis_tready = (w_state_q == W_LOAD);
  assign bram_a_en     = en_q;
  assign bram_a_we     = beat;
  assign bram_a_addr   = {wb_q, a_cnt_q};
  assign bram_a_din    = beat ? s_axis_tdata : '0;
  assign bram_b_en     = en_q;
  assign bram_b_addr   = {rb_q, b_cnt_q};
  assign rd_valid      = rd_valid_q;
  assign last_channel  = r_last;
  assign bank_full     = bank_full_q;
  assign load_done     = load_done_q;
  assign tlast_err     = tlast_err_q;

endmodule
